// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: register file with one synchronous write port, two
// combinational read ports with same-cycle write bypass, optional
// hard-wired-zero R0 and a per-register pending-write scoreboard used by
// multi-cycle producers to claim a destination and by control to detect
// read-after-write hazards.
module regfile_2r1w_sb #(
   parameter int BITS      = 32,
   parameter int REGISTERS = 16,
   parameter int AW        = $clog2(REGISTERS),
   parameter bit ZERO_R0   = 1'b1
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [BITS-1:0]           wr_data,
   input  logic [AW-1:0]             rd_addr_a,
   input  logic [AW-1:0]             rd_addr_b,
   output logic [BITS-1:0]           rd_data_a,
   output logic [BITS-1:0]           rd_data_b,
   output logic                      rd_valid_a,
   output logic                      rd_valid_b,
   input  logic                      claim_en,
   input  logic [AW-1:0]             claim_addr,
   output logic                      claim_ok,
   output logic [REGISTERS-1:0]      pending_mask,
   output logic [AW:0]               pending_count,
   output logic [BITS*REGISTERS-1:0] registerStream
);

   localparam logic [AW:0] NREG = (AW+1)'(REGISTERS);

   logic [BITS-1:0] mem [REGISTERS];

   logic [BITS-1:0] reg_a, reg_b;
   logic            pend_a, pend_b, pend_c, pend_w;
   logic            eff_a, eff_b, eff_c, eff_w;
   logic            hit_a, hit_b, claim_wr_hit;
   logic            wr_take, claim_set, cnt_inc, cnt_dec;

   // An address does something only when it is in range and is not a hard-wired R0.
   function automatic logic addr_eff(input logic [AW-1:0] a);
      logic legal;
      legal = ({1'b0, a} < NREG);
      return legal && !(ZERO_R0 && (a == '0));
   endfunction

   // Fetch stored contents and pending bits for every address port.
   // Decoding by comparison keeps out-of-range addresses from indexing past the array.
   always_comb begin
      reg_a  = '0;
      reg_b  = '0;
      pend_a = 1'b0;
      pend_b = 1'b0;
      pend_c = 1'b0;
      pend_w = 1'b0;
      for (int i = 0; i < REGISTERS; i++) begin
         if (rd_addr_a == AW'(i)) begin
            reg_a  = mem[i];
            pend_a = pending_mask[i];
         end
         if (rd_addr_b == AW'(i)) begin
            reg_b  = mem[i];
            pend_b = pending_mask[i];
         end
         if (claim_addr == AW'(i)) pend_c = pending_mask[i];
         if (wr_addr == AW'(i))    pend_w = pending_mask[i];
      end
   end

   // Read ports, bypass, claim arbitration and the net scoreboard population change.
   always_comb begin
      eff_a        = addr_eff(rd_addr_a);
      eff_b        = addr_eff(rd_addr_b);
      eff_c        = addr_eff(claim_addr);
      eff_w        = addr_eff(wr_addr);
      wr_take      = wr_en && eff_w;
      hit_a        = wr_take && (wr_addr == rd_addr_a);
      hit_b        = wr_take && (wr_addr == rd_addr_b);
      claim_wr_hit = wr_take && (wr_addr == claim_addr);

      rd_data_a  = !eff_a ? '0 : (hit_a ? wr_data : reg_a);
      rd_data_b  = !eff_b ? '0 : (hit_b ? wr_data : reg_b);
      rd_valid_a = !eff_a || hit_a || !pend_a;
      rd_valid_b = !eff_b || hit_b || !pend_b;

      claim_ok  = claim_en && (!eff_c || !pend_c || claim_wr_hit);
      claim_set = claim_ok && eff_c;

      // A claim onto an already pending register (same-cycle write) leaves the bit at 1.
      cnt_inc = claim_set && !pend_c;
      cnt_dec = wr_take && pend_w && !(claim_set && (claim_addr == wr_addr));
   end

   // Register array: async clear, single write port; R0 is never written when hard-wired.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < REGISTERS; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < REGISTERS; i++) begin
            if (wr_take && (wr_addr == AW'(i))) mem[i] <= wr_data;
         end
      end
   end

   // Scoreboard bits: a new claim wins over a same-address write clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pending_mask <= '0;
      end else begin
         for (int i = 0; i < REGISTERS; i++) begin
            if (claim_set && (claim_addr == AW'(i)))
               pending_mask[i] <= 1'b1;
            else if (wr_take && (wr_addr == AW'(i)))
               pending_mask[i] <= 1'b0;
         end
      end
   end

   // Population count tracked incrementally from the same set/clear decisions.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         pending_count <= '0;
      end else begin
         case ({cnt_inc, cnt_dec})
            2'b10:   pending_count <= pending_count + (AW+1)'(1);
            2'b01:   pending_count <= pending_count - (AW+1)'(1);
            default: pending_count <= pending_count;
         endcase
      end
   end

   // Flat debug dump of every register, register i in word i.
   always_comb begin
      registerStream = '0;
      for (int i = 0; i < REGISTERS; i++) registerStream[i*BITS +: BITS] = mem[i];
   end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb (REGISTERS=12 so that out-of-range addresses exist).
// The driver pushes expected values tagged with the cycle they belong to;
// a monitor on the falling edge pops and compares them against the DUT.
module tb_regfile_2r1w_sb;

   localparam int BITS = 32;
   localparam int REGS = 12;
   localparam int AW   = $clog2(REGS);

   localparam int K_DA = 0, K_VA = 1, K_DB = 2, K_VB = 3, K_OK = 4,
                  K_MASK = 5, K_CNT = 6, K_WORD = 7;

   logic                 clk = 1'b0;
   logic                 clr = 1'b1;
   logic                 wr_en = 1'b0;
   logic [AW-1:0]        wr_addr = '0;
   logic [BITS-1:0]      wr_data = '0;
   logic [AW-1:0]        rd_addr_a = '0;
   logic [AW-1:0]        rd_addr_b = '0;
   logic [BITS-1:0]      rd_data_a, rd_data_b;
   logic                 rd_valid_a, rd_valid_b;
   logic                 claim_en = 1'b0;
   logic [AW-1:0]        claim_addr = '0;
   logic                 claim_ok;
   logic [REGS-1:0]      pending_mask;
   logic [AW:0]          pending_count;
   logic [BITS*REGS-1:0] registerStream;

   regfile_2r1w_sb #(.BITS(BITS), .REGISTERS(REGS), .ZERO_R0(1'b1)) dut (
      .clk(clk), .clr(clr),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
      .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok),
      .pending_mask(pending_mask), .pending_count(pending_count),
      .registerStream(registerStream)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          kind;
      int          idx;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input int kind, input int idx);
      case (kind)
         K_DA:    return rd_data_a;
         K_VA:    return {31'd0, rd_valid_a};
         K_DB:    return rd_data_b;
         K_VB:    return {31'd0, rd_valid_b};
         K_OK:    return {31'd0, claim_ok};
         K_MASK:  return 32'(pending_mask);
         K_CNT:   return 32'(pending_count);
         default: return registerStream[idx*BITS +: BITS];
      endcase
   endfunction

   // Monitor: on each falling edge, compare every expectation due by now.
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.kind, e.idx);
            checks++;
            if (a !== e.val) begin
               failures++;
               $display("FAIL %s cyc=%0d actual=%h expected=%h", e.name, e.cyc, a, e.val);
            end
         end
      end
   end

   task automatic expect_val(input string name, input int kind, input int idx,
                             input logic [31:0] val);
      exp_t e;
      e.cyc = cyc; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
      q.push_back(e);
   endtask

   task automatic step(input logic we, input int wa, input logic [31:0] wd,
                       input int ra, input int rb, input logic ce, input int ca);
      @(posedge clk);
      #1;
      wr_en = we; wr_addr = AW'(wa); wr_data = wd;
      rd_addr_a = AW'(ra); rd_addr_b = AW'(rb);
      claim_en = ce; claim_addr = AW'(ca);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Held in reset: everything reads zero, reads valid
      step(0, 0, 0, 5, 3, 0, 0);
      expect_val("rst_cnt", K_CNT, 0, 0);
      expect_val("rst_mask", K_MASK, 0, 0);
      for (int i = 0; i < REGS; i++) expect_val("rst_word", K_WORD, i, 0);
      expect_val("rst_da", K_DA, 0, 0);
      expect_val("rst_va", K_VA, 0, 1);

      // Write to hard-wired R0 is ignored, no bypass
      step(1, 0, 32'hDEADBEEF, 0, 0, 0, 0);
      clr = 1'b0;
      expect_val("r0_byp_da", K_DA, 0, 0);
      expect_val("r0_byp_va", K_VA, 0, 1);
      #1;
      checks++;
      if (rd_data_a !== 32'h0) begin
         failures++;
         $display("FAIL r0_byp_direct cyc=%0d actual=%h expected=%h", cyc, rd_data_a, 32'h0);
      end
      step(0, 0, 0, 0, 0, 0, 0);
      expect_val("r0_da", K_DA, 0, 0);
      expect_val("r0_va", K_VA, 0, 1);
      expect_val("r0_word", K_WORD, 0, 0);

      // Write R5 with same-cycle bypass, then plain read
      step(1, 5, 32'h12345678, 5, 0, 0, 0);
      expect_val("r5_byp_da", K_DA, 0, 32'h12345678);
      expect_val("r5_byp_va", K_VA, 0, 1);
      expect_val("r5_word_old", K_WORD, 5, 0);
      #1;
      checks++;
      if (rd_data_a !== 32'h12345678) begin
         failures++;
         $display("FAIL r5_byp_direct cyc=%0d actual=%h expected=%h", cyc, rd_data_a, 32'h12345678);
      end
      step(0, 0, 0, 5, 5, 0, 0);
      expect_val("r5_da", K_DA, 0, 32'h12345678);
      expect_val("r5_db", K_DB, 0, 32'h12345678);
      expect_val("r5_word", K_WORD, 5, 32'h12345678);

      // Claim R3, then a second claim is refused while pending
      step(0, 0, 0, 3, 0, 1, 3);
      expect_val("c3_ok", K_OK, 0, 1);
      expect_val("c3_va_pre", K_VA, 0, 1);
      step(0, 0, 0, 3, 0, 1, 3);
      expect_val("c3_again_ok", K_OK, 0, 0);
      expect_val("c3_mask", K_MASK, 0, 32'h008);
      expect_val("c3_cnt", K_CNT, 0, 1);
      expect_val("c3_va", K_VA, 0, 0);
      #1;
      checks++;
      if (claim_ok !== 1'b0) begin
         failures++;
         $display("FAIL c3_again_direct cyc=%0d actual=%b expected=%b", cyc, claim_ok, 1'b0);
      end

      // Producer writes R3: bypass valid, count drops next cycle
      step(1, 3, 32'hA5, 3, 0, 0, 0);
      expect_val("w3_byp_da", K_DA, 0, 32'hA5);
      expect_val("w3_byp_va", K_VA, 0, 1);
      expect_val("w3_cnt_pre", K_CNT, 0, 1);
      #1;
      checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 32'hA5) begin
         failures++;
         $display("FAIL w3_byp_direct cyc=%0d actual=%b/%h expected=1/%h", cyc, rd_valid_a, rd_data_a, 32'hA5);
      end
      step(0, 0, 0, 3, 0, 0, 0);
      expect_val("w3_cnt", K_CNT, 0, 0);
      expect_val("w3_mask", K_MASK, 0, 0);
      expect_val("w3_da", K_DA, 0, 32'hA5);
      expect_val("w3_va", K_VA, 0, 1);

      // R7 pending, then write and re-claim R7 together
      step(0, 0, 0, 0, 0, 1, 7);
      expect_val("c7_ok", K_OK, 0, 1);
      step(1, 7, 32'h1, 0, 7, 1, 7);
      expect_val("wc7_ok", K_OK, 0, 1);
      expect_val("wc7_db", K_DB, 0, 32'h1);
      expect_val("wc7_vb", K_VB, 0, 1);
      expect_val("wc7_cnt_pre", K_CNT, 0, 1);
      #1;
      checks++;
      if (claim_ok !== 1'b1) begin
         failures++;
         $display("FAIL wc7_ok_direct cyc=%0d actual=%b expected=%b", cyc, claim_ok, 1'b1);
      end
      step(0, 0, 0, 0, 7, 0, 0);
      expect_val("wc7_mask", K_MASK, 0, 32'h080);
      expect_val("wc7_cnt", K_CNT, 0, 1);
      expect_val("wc7_word", K_WORD, 7, 32'h1);
      expect_val("wc7_db2", K_DB, 0, 32'h1);
      expect_val("wc7_vb2", K_VB, 0, 0);

      // Write R7 (clears) and claim R9 in one cycle: net count unchanged
      step(1, 7, 32'h55, 0, 0, 1, 9);
      expect_val("c9_ok", K_OK, 0, 1);
      step(0, 0, 0, 7, 0, 0, 0);
      expect_val("c9_mask", K_MASK, 0, 32'h200);
      expect_val("c9_cnt", K_CNT, 0, 1);
      expect_val("w7_word", K_WORD, 7, 32'h55);
      expect_val("w7_va", K_VA, 0, 1);

      // Illegal address 13: write ignored, read 0/valid, claim ok with no effect
      step(1, 13, 32'h77, 13, 13, 1, 13);
      expect_val("ill_da", K_DA, 0, 0);
      expect_val("ill_va", K_VA, 0, 1);
      expect_val("ill_vb", K_VB, 0, 1);
      expect_val("ill_ok", K_OK, 0, 1);
      #1;
      checks++;
      if (rd_data_a !== 32'h0 || rd_valid_a !== 1'b1) begin
         failures++;
         $display("FAIL ill_direct cyc=%0d actual=%h/%b expected=0/1", cyc, rd_data_a, rd_valid_a);
      end
      step(0, 0, 0, 5, 0, 0, 0);
      expect_val("ill_mask", K_MASK, 0, 32'h200);
      expect_val("ill_cnt", K_CNT, 0, 1);
      expect_val("ill_word1", K_WORD, 1, 0);
      expect_val("ill_word5", K_WORD, 5, 32'h12345678);

      // Last legal register 11
      step(1, 11, 32'h3C, 0, 0, 0, 0);
      step(0, 0, 0, 11, 0, 0, 0);
      expect_val("r11_da", K_DA, 0, 32'h3C);
      expect_val("r11_word", K_WORD, 11, 32'h3C);

      // Claim R2 and R4, then pulse clr between edges
      step(0, 0, 0, 0, 0, 1, 2);
      expect_val("c2_ok", K_OK, 0, 1);
      step(0, 0, 0, 0, 0, 1, 4);
      expect_val("c4_ok", K_OK, 0, 1);
      step(0, 0, 0, 5, 0, 0, 0);
      expect_val("c24_mask", K_MASK, 0, 32'h214);
      expect_val("c24_cnt", K_CNT, 0, 3);
      expect_val("c24_da", K_DA, 0, 32'h12345678);
      step(0, 0, 0, 5, 11, 0, 0);
      expect_val("arst_mask", K_MASK, 0, 0);
      expect_val("arst_cnt", K_CNT, 0, 0);
      expect_val("arst_da", K_DA, 0, 0);
      expect_val("arst_db", K_DB, 0, 0);
      for (int i = 0; i < REGS; i++) expect_val("arst_word", K_WORD, i, 0);
      #1 clr = 1'b1;
      #2 clr = 1'b0;

      // Normal operation resumes after the pulse
      step(1, 2, 32'h99, 0, 2, 1, 4);
      expect_val("post_db", K_DB, 0, 32'h99);
      expect_val("post_ok", K_OK, 0, 1);
      #1;
      checks++;
      if (rd_data_b !== 32'h99) begin
         failures++;
         $display("FAIL post_db_direct cyc=%0d actual=%h expected=%h", cyc, rd_data_b, 32'h99);
      end
      step(0, 0, 0, 2, 0, 0, 0);
      expect_val("post_da", K_DA, 0, 32'h99);
      expect_val("post_mask", K_MASK, 0, 32'h010);
      expect_val("post_cnt", K_CNT, 0, 1);

      step(0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         failures++;
         $display("FAIL %s cyc=%0d actual=unchecked expected=%h", e.name, e.cyc, e.val);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
